mmio_input: RTL and testbench

MMIO_INPUT -- requirements
Module: mmio_input

---
 rtl/mmio_input.sv | 117 +++++++++++
 tb/tb_mmio_input.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_input.sv
// Memory-mapped push-button and slide-switch input block.
// Buttons are synchronized, debounced and latch sticky rising-edge events.
module mmio_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NBTN            = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic            memwrite,
  input  logic [31:0]     wd,
  input  logic [NBTN-1:0] btn,
  input  logic [3:0]      sw,
  output logic [31:0]     rdata,
  output logic            sel,
  output logic            irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] A_STATE = 32'h0000_0058;
  localparam logic [31:0] A_EVENT = 32'h0000_005C;
  localparam logic [31:0] A_SW    = 32'h0000_0060;

  logic [NBTN-1:0] btn_s1;
  logic [NBTN-1:0] btn_s2;
  logic [3:0]      sw_s1;
  logic [3:0]      sw_s2;

  logic [NBTN-1:0] db;
  logic [NBTN-1:0] db_next;
  logic [NBTN-1:0] rise;
  logic [NBTN-1:0] btn_event;
  logic [NBTN-1:0] ev_clr;

  logic [CW-1:0] cnt      [NBTN];
  logic [CW-1:0] cnt_next [NBTN];

  logic hit_state;
  logic hit_event;
  logic hit_sw;

  logic unused_wd;
  assign unused_wd = ^wd[31:NBTN];

  assign hit_state = (addr == A_STATE);
  assign hit_event = (addr == A_EVENT);
  assign hit_sw    = (addr == A_SW);

  // Two-flop synchronizers for every raw level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Counter restarts whenever the synced level agrees with db
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      db_next[i]  = db[i];
      cnt_next[i] = '0;
      if (btn_s2[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_next[i] = ~db[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = db_next & ~db;

  assign ev_clr = (memwrite && hit_event) ?
                  wd[NBTN-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db        <= '0;
      btn_event <= '0;
      for (int i = 0; i < NBTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db        <= db_next;
      // A new edge beats a same-cycle clear
      btn_event <= (btn_event & ~ev_clr) | rise;
      for (int i = 0; i < NBTN; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign irq = |btn_event;
  assign sel = hit_state | hit_event | hit_sw;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_state: rdata = 32'(db);
      hit_event: rdata = 32'(btn_event);
      hit_sw:    rdata = 32'(sw_s2);
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_input.sv
// Scoreboard bench for mmio_input with DEBOUNCE_CYCLES=4, NBTN=4.
// Stimulus queues expected reads; a negedge monitor pops and compares.
module tb_mmio_input;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        memwrite;
  logic [31:0] wd;
  logic [3:0]  btn;
  logic [3:0]  sw;
  logic [31:0] rdata;
  logic        sel;
  logic        irq;

  logic rd_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        sel;
    logic        irq;
  } exp_t;

  exp_t q[$];

  mmio_input #(
    .DEBOUNCE_CYCLES(4),
    .NBTN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .memwrite(memwrite),
    .wd(wd),
    .btn(btn),
    .sw(sw),
    .rdata(rdata),
    .sel(sel),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_req) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty got rdata=%h", rdata);
      end else begin
        e = q.pop_front();
        if (rdata !== e.data || sel !== e.sel ||
            irq !== e.irq) begin
          failures++;
          $display("FAIL %s got rdata=%h sel=%b irq=%b expected rdata=%h sel=%b irq=%b",
                   e.name, rdata, sel, irq,
                   e.data, e.sel, e.irq);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string n,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic s,
                    input logic i);
    exp_t e;
    e.name = n;
    e.data = d;
    e.sel  = s;
    e.irq  = i;
    q.push_back(e);
    addr   = a;
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    addr     = a;
    wd       = d;
    memwrite = 1'b1;
    tick(1);
    memwrite = 1'b0;
    wd       = '0;
  endtask

  initial begin
    reset    = 1'b1;
    addr     = '0;
    memwrite = 1'b0;
    wd       = '0;
    btn      = '0;
    sw       = '0;
    tick(1);

    rd("rst_state", 32'h58, 32'h0, 1'b1, 1'b0);
    rd("rst_event", 32'h5C, 32'h0, 1'b1, 1'b0);
    rd("rst_sw",    32'h60, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;

    // Clean press: db rises exactly 6 edges later
    btn = 4'b0001;
    tick(5);
    rd("press_early", 32'h58, 32'h0, 1'b1, 1'b0);
    rd("press_state", 32'h58, 32'h1, 1'b1, 1'b1);
    rd("press_event", 32'h5C, 32'h1, 1'b1, 1'b1);
    wr(32'h5C, 32'h1);
    rd("press_clr",   32'h5C, 32'h0, 1'b1, 1'b0);
    rd("press_held",  32'h58, 32'h1, 1'b1, 1'b0);

    // Three-cycle glitch on btn[1] is filtered
    btn = 4'b0011;
    for (int k = 0; k < 3; k++)
      rd("glitch_hi", 32'h58, 32'h1, 1'b1, 1'b0);
    btn = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      rd("glitch_st", 32'h58, 32'h1, 1'b1, 1'b0);
      rd("glitch_ev", 32'h5C, 32'h0, 1'b1, 1'b0);
    end

    // Release, then press buttons 0 and 2 together
    btn = 4'b0000;
    tick(8);
    rd("release_st", 32'h58, 32'h0, 1'b1, 1'b0);
    rd("release_ev", 32'h5C, 32'h0, 1'b1, 1'b0);
    btn = 4'b0101;
    tick(7);
    rd("dual_event", 32'h5C, 32'h5, 1'b1, 1'b1);
    wr(32'h58, 32'hFFFF_FFFF);
    wr(32'h60, 32'hFFFF_FFFF);
    wr(32'h54, 32'hFFFF_FFFF);
    wr(32'h5D, 32'hFFFF_FFFF);
    rd("bad_wr_ev", 32'h5C, 32'h5, 1'b1, 1'b1);
    rd("bad_wr_st", 32'h58, 32'h5, 1'b1, 1'b1);
    rd("no_rd_clr", 32'h5C, 32'h5, 1'b1, 1'b1);
    wr(32'h5C, 32'h4);
    rd("w1c_bit2",  32'h5C, 32'h1, 1'b1, 1'b1);
    wr(32'h5C, 32'h1);
    rd("w1c_bit0",  32'h5C, 32'h0, 1'b1, 1'b0);

    // W1C on the exact edge db[2] rises
    btn = 4'b0001;
    tick(8);
    rd("b2_low", 32'h58, 32'h1, 1'b1, 1'b0);
    btn = 4'b0101;
    tick(4);
    rd("race_pre", 32'h5C, 32'h0, 1'b1, 1'b0);
    wr(32'h5C, 32'h4);
    rd("race_set", 32'h5C, 32'h4, 1'b1, 1'b1);
    wr(32'h5C, 32'h4);
    rd("race_clr", 32'h5C, 32'h0, 1'b1, 1'b0);

    // Switches pass only the synchronizer
    sw = 4'b1010;
    rd("sw_lat0", 32'h60, 32'h0, 1'b1, 1'b0);
    rd("sw_lat1", 32'h60, 32'h0, 1'b1, 1'b0);
    rd("sw_val",  32'h60, 32'hA, 1'b1, 1'b0);
    rd("miss_54", 32'h54, 32'h0, 1'b0, 1'b0);
    rd("miss_64", 32'h64, 32'h0, 1'b0, 1'b0);
    rd("miss_5a", 32'h5A, 32'h0, 1'b0, 1'b0);
    rd("miss_hi", 32'h1000_0058, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a debounce
    btn = 4'b0000;
    tick(8);
    rd("pre_rst", 32'h58, 32'h0, 1'b1, 1'b0);
    btn = 4'b0001;
    tick(4);
    reset = 1'b1;
    rd("in_rst_sw", 32'h60, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;
    tick(5);
    rd("rst_early", 32'h5C, 32'h0, 1'b1, 1'b0);
    rd("rst_event", 32'h5C, 32'h1, 1'b1, 1'b1);
    rd("rst_state", 32'h58, 32'h1, 1'b1, 1'b1);

    tick(2);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
